// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite types, widths and the byte-strobe merge helper
package axi4_lite_pkg;

   localparam int AXI4_LITE_DATA_WIDTH = 32;
   localparam int AXI4_LITE_STRB_WIDTH = 4;

   typedef enum logic [1:0] {
      AXI4_LITE_RESP_OKAY   = 2'b00,
      AXI4_LITE_RESP_EXOKAY = 2'b01,
      AXI4_LITE_RESP_SLVERR = 2'b10,
      AXI4_LITE_RESP_DECERR = 2'b11
   } axi4_lite_resp;

   typedef enum logic {
      AXI4_LITE_UNPRIVILEDGED_ACCESS = 1'b0,
      AXI4_LITE_PRIVILEDGED_ACCESS   = 1'b1
   } axi4_lite_priv;

   typedef struct packed {
      logic          instruction;
      logic          nonsecure;
      axi4_lite_priv privilege;
   } axi4_lite_prot;

   function automatic logic [AXI4_LITE_DATA_WIDTH-1:0] axi4_lite_merge(
      input logic [AXI4_LITE_DATA_WIDTH-1:0] old,
      input logic [AXI4_LITE_DATA_WIDTH-1:0] data,
      input logic [AXI4_LITE_STRB_WIDTH-1:0] strb
   );
      logic [AXI4_LITE_DATA_WIDTH-1:0] r;
      r = old;
      for (int i = 0; i < AXI4_LITE_STRB_WIDTH; i++)
         if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/axi4_lite_register_slave.sv
// axi4_lite_register_slave: AXI4-Lite register bank; optional AXI4_LITE_PROT_CHECK_EN rejects unprivileged accesses
module axi4_lite_register_slave
   import axi4_lite_pkg::*;
#(
   parameter int REG_COUNT  = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               awvalid,
   output logic                               awready,
   input  logic [ADDR_WIDTH-1:0]              awaddr,
   input  axi4_lite_prot                      awprot,
   input  logic                               wvalid,
   output logic                               wready,
   input  logic [AXI4_LITE_DATA_WIDTH-1:0]    wdata,
   input  logic [AXI4_LITE_STRB_WIDTH-1:0]    wstrb,
   output logic                               bvalid,
   input  logic                               bready,
   output axi4_lite_resp                      bresp,
   input  logic                               arvalid,
   output logic                               arready,
   input  logic [ADDR_WIDTH-1:0]              araddr,
   input  axi4_lite_prot                      arprot,
   output logic                               rvalid,
   input  logic                               rready,
   output logic [AXI4_LITE_DATA_WIDTH-1:0]    rdata,
   output axi4_lite_resp                      rresp,
   output logic [32*REG_COUNT-1:0]            reg_out,
   output logic [REG_COUNT-1:0]               reg_wr_pulse
);

   localparam int IDX_W = $clog2(REG_COUNT);
   localparam int IW    = ADDR_WIDTH - 2;

   logic [AXI4_LITE_DATA_WIDTH-1:0] regs [REG_COUNT];
   logic                            aw_held, w_held;
   logic [ADDR_WIDTH-1:0]           aw_addr;
   axi4_lite_prot                   aw_prot;
   logic [AXI4_LITE_DATA_WIDTH-1:0] w_data;
   logic [AXI4_LITE_STRB_WIDTH-1:0] w_strb;
   logic                            aw_hs, w_hs, ar_hs, commit, wr_en;
   logic [ADDR_WIDTH-1:0]           wr_addr;
   axi4_lite_prot                   wr_prot;
   logic [AXI4_LITE_DATA_WIDTH-1:0] wr_data;
   logic [AXI4_LITE_STRB_WIDTH-1:0] wr_strb;
   logic [IW-1:0]                   wr_idx, rd_idx;
   logic                            wr_in_range, rd_in_range;
   axi4_lite_resp                   wr_resp, rd_resp;
   logic                            unused_bits;

   assign awready = !aw_held && !bvalid;
   assign wready  = !w_held && !bvalid;
   assign arready = !rvalid;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign ar_hs   = arvalid && arready;
   assign commit  = (aw_hs || aw_held) && (w_hs || w_held);

   // A held beat takes precedence: while its flag is set the channel cannot handshake
   assign wr_addr = aw_held ? aw_addr : awaddr;
   assign wr_prot = aw_held ? aw_prot : awprot;
   assign wr_data = w_held ? w_data : wdata;
   assign wr_strb = w_held ? w_strb : wstrb;

   // REG_COUNT is a power of two, so an index is in range exactly when its upper bits are zero
   assign wr_idx      = wr_addr[ADDR_WIDTH-1:2];
   assign rd_idx      = araddr[ADDR_WIDTH-1:2];
   assign wr_in_range = (wr_idx >> IDX_W) == '0;
   assign rd_in_range = (rd_idx >> IDX_W) == '0;

`ifdef AXI4_LITE_PROT_CHECK_EN
   assign wr_resp = !wr_in_range ? AXI4_LITE_RESP_DECERR :
                    (wr_prot.privilege == AXI4_LITE_UNPRIVILEDGED_ACCESS) ? AXI4_LITE_RESP_SLVERR :
                    AXI4_LITE_RESP_OKAY;
   assign rd_resp = !rd_in_range ? AXI4_LITE_RESP_DECERR :
                    (arprot.privilege == AXI4_LITE_UNPRIVILEDGED_ACCESS) ? AXI4_LITE_RESP_SLVERR :
                    AXI4_LITE_RESP_OKAY;
`else
   assign wr_resp = wr_in_range ? AXI4_LITE_RESP_OKAY : AXI4_LITE_RESP_DECERR;
   assign rd_resp = rd_in_range ? AXI4_LITE_RESP_OKAY : AXI4_LITE_RESP_DECERR;
`endif

   assign wr_en       = commit && (wr_resp == AXI4_LITE_RESP_OKAY);
   assign unused_bits = ^{awprot, arprot, wr_prot, wr_addr[1:0], araddr[1:0]};

   for (genvar i = 0; i < REG_COUNT; i++) begin : g_out
      assign reg_out[32*i +: 32] = regs[i];
   end

   // Write path: capture AW/W independently, commit when both are present, hold B until accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_addr      <= '0;
         aw_prot      <= '0;
         w_data       <= '0;
         w_strb       <= '0;
         bvalid       <= 1'b0;
         bresp        <= AXI4_LITE_RESP_OKAY;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (bvalid && bready) bvalid <= 1'b0;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_resp;
            if (wr_en) begin
               regs[wr_idx[IDX_W-1:0]]         <= axi4_lite_merge(regs[wr_idx[IDX_W-1:0]], wr_data, wr_strb);
               reg_wr_pulse[wr_idx[IDX_W-1:0]] <= 1'b1;
            end
         end else begin
            if (aw_hs) begin
               aw_held <= 1'b1;
               aw_addr <= awaddr;
               aw_prot <= awprot;
            end
            if (w_hs) begin
               w_held <= 1'b1;
               w_data <= wdata;
               w_strb <= wstrb;
            end
         end
      end
   end

   // Read path: sample the register on AR handshake and hold R until accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= AXI4_LITE_RESP_OKAY;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rresp  <= rd_resp;
         rdata  <= (rd_resp == AXI4_LITE_RESP_OKAY) ? regs[rd_idx[IDX_W-1:0]] : '0;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_register_slave.sv
// tb_axi4_lite_register_slave: directed and randomized checks against a register-array model
module tb_axi4_lite_register_slave;
   import axi4_lite_pkg::*;

   localparam int N  = 8;
   localparam int AW = 12;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
   logic [AW-1:0]   awaddr = '0, araddr = '0;
   axi4_lite_prot   awprot = '0, arprot = '0;
   logic [31:0]     wdata = '0;
   logic [3:0]      wstrb = '0;
   logic            awready, wready, bvalid, arready, rvalid;
   axi4_lite_resp   bresp, rresp;
   logic [31:0]     rdata;
   logic [32*N-1:0] reg_out;
   logic [N-1:0]    reg_wr_pulse;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [N];

   axi4_lite_register_slave #(.REG_COUNT(N), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] flat();
      logic [255:0] r;
      for (int i = 0; i < N; i++) r[32*i +: 32] = model[i];
      return r;
   endfunction

   function automatic logic [1:0] resp_for(input logic [AW-1:0] a, input logic [2:0] p);
      if (int'(a) / 4 >= N) return 2'd3;
`ifdef AXI4_LITE_PROT_CHECK_EN
      if (p[0] == 1'b0) return 2'd2;
`else
      if (p === 3'bxxx) return 2'd0;
`endif
      return 2'd0;
   endfunction

   // mode 0: AW and W together; 1: W first, AW gap cycles later; 2: AW first
   task automatic write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input int mode, input int gap, input int bdly);
      logic [1:0]  r;
      logic [31:0] mask;
      logic [7:0]  ep;
      int          idx;
      r    = resp_for(a, p);
      idx  = int'(a) / 4;
      mask = 0;
      for (int i = 0; i < 4; i++) if (s[i]) mask = mask + (32'hFF << (8 * i));
      ep   = (r == 2'd0) ? 8'(1 << idx) : 8'h0;
      @(negedge clk);
      bready = (bdly == 0);
      awaddr = a; awprot = axi4_lite_prot'(p); wdata = d; wstrb = s;
      check("awready_idle", awready, 1);
      check("wready_idle", wready, 1);
      if (mode != 2) wvalid = 1;
      if (mode != 1) awvalid = 1;
      if (mode != 0) begin
         @(posedge clk); #1;
         awvalid = 0; wvalid = 0;
         check("held_awready", awready, mode == 1);
         check("held_wready", wready, mode == 2);
         check("held_bvalid", bvalid, 0);
         repeat (gap - 1) begin
            @(posedge clk); #1;
            check("held_awready", awready, mode == 1);
            check("held_wready", wready, mode == 2);
            check("held_bvalid", bvalid, 0);
         end
         @(negedge clk);
         if (mode == 1) awvalid = 1; else wvalid = 1;
      end
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      if (r == 2'd0) model[idx] = (model[idx] & ~mask) | (d & mask);
      check("bvalid", bvalid, 1);
      check("bresp", bresp, r);
      check("wr_pulse", reg_wr_pulse, ep);
      check("reg_out", reg_out, flat());
      check("awready_busy", awready, 0);
      check("wready_busy", wready, 0);
      repeat (bdly) begin
         @(posedge clk); #1;
         check("bvalid_hold", bvalid, 1);
         check("bresp_hold", bresp, r);
         check("wr_pulse_once", reg_wr_pulse, 0);
      end
      if (bdly != 0) begin
         @(negedge clk);
         bready = 1;
      end
      @(posedge clk); #1;
      check("bvalid_clear", bvalid, 0);
      check("wr_pulse_clear", reg_wr_pulse, 0);
      check("awready_back", awready, 1);
   endtask

   task automatic read(input logic [AW-1:0] a, input logic [2:0] p, input int rdly);
      logic [1:0]  r;
      logic [31:0] ed;
      r  = resp_for(a, p);
      ed = (r == 2'd0) ? model[int'(a) / 4] : 32'h0;
      @(negedge clk);
      araddr = a; arprot = axi4_lite_prot'(p); arvalid = 1; rready = (rdly == 0);
      check("arready_idle", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      check("rvalid", rvalid, 1);
      check("rdata", rdata, ed);
      check("rresp", rresp, r);
      repeat (rdly) begin
         @(posedge clk); #1;
         check("rvalid_hold", rvalid, 1);
         check("rdata_hold", rdata, ed);
         check("arready_busy", arready, 0);
      end
      if (rdly != 0) begin
         @(negedge clk);
         rready = 1;
      end
      @(posedge clk); #1;
      check("rvalid_clear", rvalid, 0);
      check("arready_back", arready, 1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) model[i] = 0;
      #1 rst_n = 0;
      repeat (2) @(negedge clk);
      check("rst_awready", awready, 1);
      check("rst_wready", wready, 1);
      check("rst_arready", arready, 1);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rresp", rresp, 0);
      check("rst_rdata", rdata, 0);
      check("rst_reg_out", reg_out, 0);
      check("rst_pulse", reg_wr_pulse, 0);
      rst_n = 1;

      write(12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 0, 1, 0);
      check("tp1_reg1", reg_out[63:32], 32'hDEADBEEF);
      write(12'h004, 32'h000000AA, 4'h1, 3'b001, 1, 3, 0);
      check("tp2_reg1", reg_out[63:32], 32'hDEADBEAA);
      read(12'h006, 3'b001, 4);
      write(12'h020, 32'h11111111, 4'hF, 3'b001, 0, 1, 0);
      read(12'h020, 3'b001, 0);
      write(12'h01C, 32'hCAFEF00D, 4'h0, 3'b001, 2, 2, 2);

      @(negedge clk);
      awaddr = 12'h000; wdata = 32'h12345678; wstrb = 4'hF; awprot = axi4_lite_prot'(3'b001);
      araddr = 12'h000; arprot = axi4_lite_prot'(3'b001);
      awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      model[0] = 32'h12345678;
      check("same_edge_rdata", rdata, 0);
      check("same_edge_rvalid", rvalid, 1);
      check("same_edge_bvalid", bvalid, 1);
      check("same_edge_reg0", reg_out[31:0], 32'h12345678);
      @(posedge clk); #1;
      check("same_edge_rclear", rvalid, 0);
      check("same_edge_bclear", bvalid, 0);
      read(12'h000, 3'b001, 0);

      write(12'h000, 32'h00000055, 4'hF, 3'b000, 0, 1, 0);
      write(12'h000, 32'h00000055, 4'hF, 3'b001, 0, 1, 0);
      write(12'h008, 32'h0BADBEEF, 4'hF, 3'b000, 0, 1, 0);
      read(12'h008, 3'b000, 1);
      read(12'h008, 3'b001, 0);

      for (int k = 0; k < 40; k++) begin
         logic [AW-1:0] a;
         a = AW'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
         write(a, $urandom, 4'($urandom), 3'($urandom), int'($urandom_range(0, 2)),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
         a = AW'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
         read(a, 3'($urandom), int'($urandom_range(0, 2)));
      end

      @(negedge clk);
      wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
      araddr = 12'h004; arprot = axi4_lite_prot'(3'b001); arvalid = 1; rready = 0;
      @(posedge clk); #1;
      wvalid = 0; arvalid = 0;
      check("pre_rst_wready", wready, 0);
      check("pre_rst_rvalid", rvalid, 1);
      #2 rst_n = 0;
      #1;
      for (int i = 0; i < N; i++) model[i] = 0;
      check("mid_rst_wready", wready, 1);
      check("mid_rst_awready", awready, 1);
      check("mid_rst_arready", arready, 1);
      check("mid_rst_rvalid", rvalid, 0);
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_rdata", rdata, 0);
      check("mid_rst_reg_out", reg_out, 0);
      @(negedge clk);
      rst_n = 1; rready = 1;
      write(12'h008, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 1, 0);
      read(12'h008, 3'b001, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
